vdp2_sync_fifo: RTL

- Parametrised single-clock FIFO for VDP2 CPU/DMA write buffering; successor to the fixed 8x36 VDP2 write FIFO.
- Adds configurable width, depth and show-ahead/normal read mode, plus occupancy count, almost-full/almost-empty thresholds, synchronous clear and built-in overflow/underflow protection.
- Sits between the VDP2 bus interface (writer) and the VRAM/CRAM arbiter (reader).

---
 rtl/vdp2_mem_pkg.sv | 14 +
 rtl/vdp2_sync_fifo_if.sv | 40 ++++
 rtl/vdp2_fifo_ram.sv | 22 ++
 rtl/vdp2_sync_fifo.sv | 127 ++++++++++++
 4 files changed

// File: rtl/vdp2_mem_pkg.sv
// Shared VDP2 memory-path definitions: write-FIFO default geometry and the
// packed layout of one buffered CPU/DMA write.
package vdp2_mem_pkg;

    localparam int VDP2_WFIFO_DATA_W = 36;
    localparam int VDP2_WFIFO_ADDR_W = 3;

    typedef struct packed {
        logic [3:0]  byte_en;
        logic [18:0] addr;
        logic [12:0] ctrl;
    } vdp2_wfifo_entry_t;

endpackage

// File: rtl/vdp2_sync_fifo_if.sv
// Write/read/status bundle between the VDP2 bus side (master) and the FIFO
// (slave). Diagnostic signals exist only when VDP2_FIFO_DIAG_EN is defined.
interface vdp2_sync_fifo_if #(
    parameter int DATA_W = vdp2_mem_pkg::VDP2_WFIFO_DATA_W,
    parameter int ADDR_W = vdp2_mem_pkg::VDP2_WFIFO_ADDR_W
) ();
    logic              sclr;
    logic [DATA_W-1:0] data;
    logic              wrreq;
    logic              rdreq;
    logic [DATA_W-1:0] q;
    logic              empty;
    logic              full;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   usedw;
`ifdef VDP2_FIFO_DIAG_EN
    logic              ovf;
    logic              udf;
    logic [ADDR_W:0]   hwm;

    modport master (
        output sclr, data, wrreq, rdreq,
        input  q, empty, full, almost_full, almost_empty, usedw, ovf, udf, hwm
    );
    modport slave (
        input  sclr, data, wrreq, rdreq,
        output q, empty, full, almost_full, almost_empty, usedw, ovf, udf, hwm
    );
`else
    modport master (
        output sclr, data, wrreq, rdreq,
        input  q, empty, full, almost_full, almost_empty, usedw
    );
    modport slave (
        input  sclr, data, wrreq, rdreq,
        output q, empty, full, almost_full, almost_empty, usedw
    );
`endif
endinterface

// File: rtl/vdp2_fifo_ram.sv
// FIFO storage: one synchronous write port, one asynchronous read port.
// No reset on the array; contents survive RST/SCLR.
module vdp2_fifo_ram #(
    parameter int DATA_W = 36,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [1 << ADDR_W];

    // write port
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/vdp2_sync_fifo.sv
// Single-clock VDP2 write FIFO with occupancy/threshold flags, synchronous
// clear and full/empty protection. Optional diagnostics (OVF/UDF/HWM) are
// built when VDP2_FIFO_DIAG_EN is defined.
module vdp2_sync_fifo
    import vdp2_mem_pkg::*;
#(
    parameter int DATA_W    = VDP2_WFIFO_DATA_W,
    parameter int ADDR_W    = VDP2_WFIFO_ADDR_W,
    parameter bit SHOWAHEAD = 1'b1,
    parameter int AF_LEVEL  = (1 << ADDR_W) - 2,
    parameter int AE_LEVEL  = 1
) (
    input logic             clk,
    input logic             rst,
    vdp2_sync_fifo_if.slave bus
);
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(1 << ADDR_W);
    localparam logic [ADDR_W:0] AF_CNT    = (ADDR_W + 1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_CNT    = (ADDR_W + 1)'(AE_LEVEL);
    localparam logic            AF_RST    = (AF_LEVEL == 0);

    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   count, count_nxt;
    logic              empty_r, full_r, af_r, ae_r;
    logic              wr_acc, rd_acc;
    logic [DATA_W-1:0] rd_data;

    assign wr_acc = bus.wrreq & ~full_r;
    assign rd_acc = bus.rdreq & ~empty_r;

    vdp2_fifo_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc & ~bus.sclr),
        .waddr (wr_ptr),
        .wdata (bus.data),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    // next occupancy: simultaneous accepted read and write cancel out
    always_comb begin
        count_nxt = count;
        if (wr_acc && !rd_acc)      count_nxt = count + 1'b1;
        else if (rd_acc && !wr_acc) count_nxt = count - 1'b1;
    end

    // pointers, count and flags registered from the next count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            empty_r <= 1'b1;
            full_r  <= 1'b0;
            af_r    <= AF_RST;
            ae_r    <= 1'b1;
        end else if (bus.sclr) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            empty_r <= 1'b1;
            full_r  <= 1'b0;
            af_r    <= AF_RST;
            ae_r    <= 1'b1;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            count   <= count_nxt;
            empty_r <= (count_nxt == '0);
            full_r  <= (count_nxt == DEPTH_CNT);
            af_r    <= (count_nxt >= AF_CNT);
            ae_r    <= (count_nxt <= AE_CNT);
        end
    end

    assign bus.empty        = empty_r;
    assign bus.full         = full_r;
    assign bus.almost_full  = af_r;
    assign bus.almost_empty = ae_r;
    assign bus.usedw        = count;

    generate
        if (SHOWAHEAD) begin : g_showahead
            assign bus.q = empty_r ? '0 : rd_data;
        end else begin : g_registered
            logic [DATA_W-1:0] q_r;

            // Q loads the head entry on an accepted read, otherwise holds
            always_ff @(posedge clk or posedge rst) begin
                if (rst)           q_r <= '0;
                else if (bus.sclr) q_r <= '0;
                else if (rd_acc)   q_r <= rd_data;
            end

            assign bus.q = q_r;
        end
    endgenerate

`ifdef VDP2_FIFO_DIAG_EN
    logic            ovf_r, udf_r;
    logic [ADDR_W:0] hwm_r;

    // sticky overflow/underflow and high-water mark, same edge as usedw
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_r <= 1'b0;
            udf_r <= 1'b0;
            hwm_r <= '0;
        end else if (bus.sclr) begin
            ovf_r <= 1'b0;
            udf_r <= 1'b0;
            hwm_r <= '0;
        end else begin
            if (bus.wrreq && full_r)  ovf_r <= 1'b1;
            if (bus.rdreq && empty_r) udf_r <= 1'b1;
            if (count_nxt > hwm_r)    hwm_r <= count_nxt;
        end
    end

    assign bus.ovf = ovf_r;
    assign bus.udf = udf_r;
    assign bus.hwm = hwm_r;
`endif
endmodule
